reg_bank_slave: RTL and testbench

//  Parametrised register-bank target on the en/wr/addr/wdata bus. Stores accepted writes,

---
 rtl/reg_bank_pkg.sv | 28 ++
 rtl/reg_bank_mem.sv | 60 ++++++
 rtl/reg_bank_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_reg_bank_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared types and constants for the register-bank target.
//               Holds the response FSM state encoding, the read-latency
//               ceiling and the width of the write counter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    // Upper bound on the configurable read latency (cycles).
    localparam int RD_LAT_MAX = 4;

    // Width of the accepted-write counter.
    localparam int WR_COUNT_W = 16;

    // Width of the latency down-counter; holds values 0..RD_LAT_MAX-2.
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

    // Response FSM states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } state_e;

endpackage : reg_bank_pkg
`default_nettype wire

// File: rtl/reg_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_mem
// Description : DEPTH x DATA_W register array with synchronous reset, one
//               write port and one registered read port. The read register
//               loads only when a read is issued and otherwise holds, so the
//               response data stays stable while it waits to be consumed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1       clock, rising edge
//   rst      in   1       synchronous reset, active-high; clears array and
//                         read register
//   i_we     in   1       write enable
//   i_widx   in   IDX_W   write index
//   i_wdata  in   DATA_W  write data
//   i_re     in   1       read enable; loads the read register
//   i_rzero  in   1       force the loaded read data to zero (no target)
//   i_ridx   in   IDX_W   read index
//   o_rdata  out  DATA_W  registered read data
// ============================================================================
module reg_bank_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem   <= '{default: '0};
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_widx] <= i_wdata;
            end
            // The read samples the array contents as they stand before this
            // edge, which is the value the requester is owed.
            if (i_re) begin
                r_rdata <= i_rzero ? '0 : r_mem[i_ridx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : reg_bank_mem
`default_nettype wire

// File: rtl/reg_bank_slave.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_slave
// Description : Parametrised register-bank target on the en/wr/addr/wdata
//               bus. Stores accepted in-range writes, answers reads after a
//               fixed latency with a valid/ready response, flags
//               out-of-range accesses and counts accepted writes
//               (saturating).
// Revision    : 1.0 - initial release
// Config      : define WR_LOG_EN to print a simulation log line for every
//               accepted write; hardware behaviour is identical either way.
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W  data width in bits
//   ADDR_W  address width in bits
//   DEPTH   number of registers, 1..2**ADDR_W
//   RD_LAT  read latency in cycles, 1..RD_LAT_MAX
// Ports
//   clk       in   1           clock, rising edge
//   rst       in   1           synchronous reset, active-high
//   en        in   1           request strobe
//   wr        in   1           1 = write, 0 = read
//   addr      in   ADDR_W      request address
//   wdata     in   DATA_W      write data
//   ready     out  1           bank can accept a request this cycle
//   rdata     out  DATA_W      read data, valid while rvalid
//   rvalid    out  1           read response valid
//   rready    in   1           consumer accepts the read response
//   rd_err    out  1           out-of-range read, qualified by rvalid
//   wr_err    out  1           one-cycle pulse after an out-of-range write
//   wr_count  out  WR_COUNT_W  accepted in-range writes, saturating
// ============================================================================
module reg_bank_slave
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rd_err,
    output logic                  wr_err,
    output logic [WR_COUNT_W-1:0] wr_count
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("reg_bank_slave: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
        end
        if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
            $error("reg_bank_slave: DEPTH=%0d not in 1..2**ADDR_W", DEPTH);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit wider than the address so DEPTH == 2**ADDR_W is representable;
    // the range check then covers the full address with no wrap.
    localparam logic [ADDR_W:0]           c_depth_lim = (ADDR_W + 1)'(DEPTH);
    localparam logic [LAT_CNT_W-1:0]      c_lat_load  = LAT_CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [LAT_CNT_W-1:0]      c_lat_one   = LAT_CNT_W'(1);
    localparam logic [WR_COUNT_W-1:0]     c_cnt_one   = WR_COUNT_W'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_e                r_state;
    state_e                w_state_nxt;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;
    logic [LAT_CNT_W-1:0]  w_lat_cnt_nxt;
    logic                  r_rvalid;
    logic                  w_rvalid_nxt;
    logic                  r_rd_err;
    logic                  w_rd_err_nxt;
    logic                  r_wr_err;
    logic [WR_COUNT_W-1:0] r_wr_count;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_wr_ok;
    logic                  w_rd_go;
    logic [DATA_W-1:0]     w_mem_rdata;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign w_ready    = (r_state == IDLE);
    assign w_accept   = en && w_ready;
    assign w_in_range = ({1'b0, addr} < c_depth_lim);
    assign w_wr_ok    = w_accept && wr && w_in_range;
    assign w_rd_go    = w_accept && !wr;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    reg_bank_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_ok),
        .i_widx  (addr[IDX_W-1:0]),
        .i_wdata (wdata),
        .i_re    (w_rd_go),
        .i_rzero (!w_in_range),
        .i_ridx  (addr[IDX_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // ------------------------------------------------------------------------
    // Response FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_rvalid  <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rd_err  <= w_rd_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Response FSM: next state
    // The data is captured at the accepting edge; rvalid is registered out of
    // RD_RESP so it asserts exactly RD_LAT edges after acceptance. RD_RESP is
    // left only once the consumer has actually seen rvalid with rready.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_rvalid_nxt  = r_rvalid;
        w_rd_err_nxt  = r_rd_err;

        case (r_state)
            IDLE: begin
                if (w_rd_go) begin
                    w_state_nxt   = (RD_LAT > 1) ? RD_WAIT : RD_RESP;
                    w_lat_cnt_nxt = c_lat_load;
                    w_rd_err_nxt  = !w_in_range;
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = RD_RESP;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - c_lat_one;
                end
            end
            RD_RESP: begin
                if (r_rvalid && rready) begin
                    w_state_nxt  = IDLE;
                    w_rvalid_nxt = 1'b0;
                    w_rd_err_nxt = 1'b0;
                end else begin
                    w_rvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_rvalid_nxt = 1'b0;
                w_rd_err_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write status: error pulse and saturating counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err   <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_wr_err <= w_accept && wr && !w_in_range;
            if (w_wr_ok && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional write log (simulation only)
    // ------------------------------------------------------------------------
`ifdef WR_LOG_EN
    always_ff @(posedge clk) begin
        if (!rst && w_accept && wr) begin
            if (w_in_range) begin
                $display("[%0t] Write data = 0x%0h to addr[0x%0h]", $time, wdata, addr);
            end else begin
                $display("[%0t] Write addr[0x%0h] out of range", $time, addr);
            end
        end
    end
`else
    // Write logging compiled out.
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready    = w_ready;
    assign rdata    = w_mem_rdata;
    assign rvalid   = r_rvalid;
    assign rd_err   = r_rd_err;
    assign wr_err   = r_wr_err;
    assign wr_count = r_wr_count;

endmodule : reg_bank_slave
`default_nettype wire

// File: tb/tb_reg_bank_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_slave
// Description : Self-checking bench for reg_bank_slave. The main instance
//               uses RD_LAT=2; two further instances with RD_LAT=1 and
//               RD_LAT=4 share the same bus and are used for latency checks.
//               Expected read responses come from a reference array and are
//               queued when a read is issued, then popped on rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_slave;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              wr = 1'b0;
    logic              rready = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;

    logic              ready2, rvalid2, rd_err2, wr_err2;
    logic [DATA_W-1:0] rdata2;
    logic [15:0]       wr_count2;
    logic              ready1, rvalid1, rd_err1, wr_err1;
    logic [DATA_W-1:0] rdata1;
    logic [15:0]       wr_count1;
    logic              ready4, rvalid4, rd_err4, wr_err4;
    logic [DATA_W-1:0] rdata4;
    logic [15:0]       wr_count4;

    always #5 clk = ~clk;

    reg_bank_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .rready(rready),
        .rd_err(rd_err2), .wr_err(wr_err2), .wr_count(wr_count2)
    );

    reg_bank_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .rready(rready),
        .rd_err(rd_err1), .wr_err(wr_err1), .wr_count(wr_count1)
    );

    reg_bank_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready4), .rdata(rdata4), .rvalid(rvalid4), .rready(rready),
        .rd_err(rd_err4), .wr_err(wr_err4), .wr_count(wr_count4)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] model [DEPTH];
    logic [15:0]       exp_count;
    rsp_t              sb [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_count = '0;
        sb.delete();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic in_rng;
        in_rng = (a < DEPTH);
        check("ready_before_write", ready2, 1);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        step();
        en = 1'b0;
        if (in_rng) begin
            model[a[3:0]] = d;
            exp_count     = exp_count + 16'd1;
        end
        check("wr_err_after_write", wr_err2, !in_rng);
        check("wr_count_after_write", wr_count2, exp_count);
    endtask

    // Wait for rvalid on the main instance, then pop and compare.
    task automatic wait_resp(input string tag);
        int   cyc;
        rsp_t e;
        cyc = 0;
        while (!rvalid2 && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_scoreboard: observed rvalid expected no response", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rdata2, e.data);
            check({tag, "_rd_err"}, rd_err2, e.err);
        end
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a);
        rsp_t e;
        rready = 1'b1;
        check({tag, "_ready_before"}, ready2, 1);
        en = 1'b1; wr = 1'b0; addr = a;
        step();
        en = 1'b0;
        e.err  = (a >= DEPTH);
        e.data = e.err ? '0 : model[a[3:0]];
        sb.push_back(e);
        wait_resp(tag);
        step();
        check({tag, "_rvalid_drop"}, rvalid2, 0);
        check({tag, "_ready_back"}, ready2, 1);
    endtask

    initial begin
        int   l1, l2, l4;
        logic [DATA_W-1:0] d1, d4;
        rsp_t e;

        // 1: reset state, then read of a never-written register
        do_reset();
        check("rst_ready", ready2, 1);
        check("rst_rvalid", rvalid2, 0);
        check("rst_wr_err", wr_err2, 0);
        check("rst_wr_count", wr_count2, 0);
        check("rst_rdata", rdata2, 0);
        check("rst_rd_err", rd_err2, 0);
        do_read("rd_a5_after_rst", 8'h05);

        // 2: write then read back
        do_write(8'h0A, 8'h11);
        do_read("rd_a0a", 8'h0A);
        check("wr_count_one", wr_count2, 1);

        // 3: out-of-range write and read
        do_write(8'h16, 8'h11);
        step();
        check("wr_err_pulse_end", wr_err2, 0);
        check("wr_count_unchanged", wr_count2, 1);
        do_read("rd_a16_oor", 8'h16);
        do_write(8'hFF, 8'h22);
        do_read("rd_aff_oor", 8'hFF);
        do_write(8'h0F, 8'h5C);
        do_read("rd_a0f_last", 8'h0F);

        // 4: response stall with rready low; requests meanwhile are ignored
        do_write(8'h03, 8'h33);
        rready = 1'b0;
        en = 1'b1; wr = 1'b0; addr = 8'h03;
        step();
        en = 1'b0;
        e.err = 1'b0; e.data = model[3];
        sb.push_back(e);
        wait_resp("stall");
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; wr = 1'(i % 2); addr = 8'(i); wdata = 8'hFF;
            step();
            check("stall_rvalid", rvalid2, 1);
            check("stall_rdata", rdata2, 8'h33);
            check("stall_ready", ready2, 0);
        end
        en = 1'b0;
        rready = 1'b1;
        step();
        check("stall_release_rvalid", rvalid2, 0);
        check("stall_release_ready", ready2, 1);
        check("stall_wr_count", wr_count2, exp_count);
        do_read("rd_a3_after_stall", 8'h03);
        do_read("rd_a1_after_stall", 8'h01);

        // 5: reset while a read waits; the response must never appear
        do_write(8'h05, 8'h77);
        en = 1'b1; wr = 1'b0; addr = 8'h05;
        step();
        en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_count = '0;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_read_rvalid", rvalid2, 0);
            step();
        end
        check("rst_mid_read_ready", ready2, 1);
        check("rst_mid_read_count", wr_count2, 0);
        for (int i = 0; i < DEPTH; i++) begin
            do_read("rd_cleared", 8'(i));
        end

        // 6: back-to-back writes, one per cycle
        en = 1'b1; wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr  = 8'(8 + i);
            wdata = 8'(8'hA0 + i);
            step();
            model[8 + i] = 8'(8'hA0 + i);
            exp_count    = exp_count + 16'd1;
            check("b2b_wr_count", wr_count2, exp_count);
            check("b2b_ready", ready2, 1);
        end
        en = 1'b0;
        check("b2b_wr_count_final", wr_count2, 4);
        for (int i = 0; i < 4; i++) begin
            do_read("rd_b2b", 8'(8 + i));
        end

        // Latency of the RD_LAT=1 and RD_LAT=4 builds alongside RD_LAT=2
        do_reset();
        do_write(8'h02, 8'h5A);
        rready = 1'b1;
        en = 1'b1; wr = 1'b0; addr = 8'h02;
        step();
        en = 1'b0;
        l1 = -1; l2 = -1; l4 = -1; d1 = '0; d4 = '0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (rvalid1 && l1 < 0) begin l1 = c; d1 = rdata1; end
            if (rvalid2 && l2 < 0) l2 = c;
            if (rvalid4 && l4 < 0) begin l4 = c; d4 = rdata4; end
        end
        check("lat1_cycles", l1, 1);
        check("lat2_cycles", l2, 2);
        check("lat4_cycles", l4, 4);
        check("lat1_rdata", d1, 8'h5A);
        check("lat4_rdata", d4, 8'h5A);
        check("lat1_wr_count", wr_count1, 1);
        check("lat4_wr_count", wr_count4, 1);
        check("lat_all_idle", {ready1, ready2, ready4}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_bank_slave
`default_nettype wire
